bpsk_demod_ctrl: RTL and testbench

Sequencing controller for the BPSK demodulator datapath in the clk_32m domain.
- On a start request it soft-resets the demodulator, latches the display mode, enables it and waits for the datapath to settle.
- It then samples the demodulator's code-rate estimate (freq, values 6/8/10 kHz) at a fixed interval and declares lock after LOCK_CNT consecutive identical valid readings.
- It supervises lock afterwards and reports timeout when no lock is reached. It sits between the key/UI logic and the demodulator.

---
 rtl/bpsk_ctrl_pkg.sv | 26 ++
 rtl/bpsk_freq_lock_chk.sv | 97 +++++++++
 rtl/bpsk_demod_ctrl.sv | 159 +++++++++++++++
 tb/tb_bpsk_demod_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_ctrl_pkg.sv
// Shared types and helpers for the BPSK demodulator sequencing controller.
//   state_t        : controller FSM states
//   FREQ_*         : legal code-rate estimates reported by the demodulator (kHz)
//   is_valid_freq  : true when a rate estimate is one of the legal values
package bpsk_ctrl_pkg;

   localparam int unsigned FREQ_W = 8;

   localparam logic [FREQ_W-1:0] FREQ_6K  = 8'd6;
   localparam logic [FREQ_W-1:0] FREQ_8K  = 8'd8;
   localparam logic [FREQ_W-1:0] FREQ_10K = 8'd10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FLUSH   = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_MEASURE = 3'd3,
      ST_LOCKED  = 3'd4,
      ST_FAIL    = 3'd5
   } state_t;

   function automatic logic is_valid_freq(input logic [FREQ_W-1:0] freq);
      return (freq == FREQ_6K) || (freq == FREQ_8K) || (freq == FREQ_10K);
   endfunction

endpackage

// File: rtl/bpsk_freq_lock_chk.sv
// Rate-estimate lock checker: generates the sample tick, tracks the previous
// sample and counts consecutive matching (acquire) or mismatching (track) ticks.
// Ports:
//   clk_32m, rst_n   : clock, async active-low reset
//   i_run            : sampling active (MEASURE or LOCKED); low clears all state
//   i_locked         : 1 = tracking against i_ref, 0 = acquiring
//   i_freq           : rate estimate from the demodulator
//   i_ref            : currently locked rate
//   o_lock_c         : this tick completes LOCK_CNT matching valid samples
//   o_unlock_c       : this tick completes LOCK_CNT mismatches against i_ref
//   o_lock_freq_c    : rate to latch on lock
module bpsk_freq_lock_chk
   import bpsk_ctrl_pkg::*;
#(
   parameter int unsigned SAMPLE_CYC = 16000,
   parameter int unsigned LOCK_CNT   = 4
) (
   input  logic              clk_32m,
   input  logic              rst_n,
   input  logic              i_run,
   input  logic              i_locked,
   input  logic [FREQ_W-1:0] i_freq,
   input  logic [FREQ_W-1:0] i_ref,
   output logic              o_lock_c,
   output logic              o_unlock_c,
   output logic [FREQ_W-1:0] o_lock_freq_c
);

   localparam int unsigned SMP_W = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
   localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);

   logic [SMP_W-1:0]  r_smp_cnt;
   logic [FREQ_W-1:0] r_prev;
   logic [CNT_W-1:0]  r_match_cnt;
   logic [CNT_W-1:0]  r_mis_cnt;

   logic              w_tick;
   logic              w_valid;
   logic [CNT_W-1:0]  w_next_match;
   logic [CNT_W-1:0]  w_next_mis;

   // Tick on the last cycle of each sample interval
   assign w_tick  = i_run && (r_smp_cnt == SMP_W'(SAMPLE_CYC - 1));
   assign w_valid = is_valid_freq(i_freq);

   // Next match/mismatch counts, saturating at LOCK_CNT
   always_comb begin
      w_next_match = '0;
      w_next_mis   = '0;
      if (w_valid && (i_freq == r_prev)) begin
         w_next_match = (r_match_cnt == CNT_W'(LOCK_CNT)) ? r_match_cnt
                                                          : r_match_cnt + CNT_W'(1);
      end else begin
         w_next_match = w_valid ? CNT_W'(1) : '0;
      end
      if (i_freq != i_ref) begin
         w_next_mis = (r_mis_cnt == CNT_W'(LOCK_CNT)) ? r_mis_cnt
                                                      : r_mis_cnt + CNT_W'(1);
      end
   end

   assign o_lock_c      = w_tick && !i_locked && (w_next_match == CNT_W'(LOCK_CNT));
   assign o_unlock_c    = w_tick &&  i_locked && (w_next_mis   == CNT_W'(LOCK_CNT));
   assign o_lock_freq_c = i_freq;

   // Sample counter, previous sample and run counters; the counter of the
   // inactive mode is held at zero so each mode starts from a clean count
   always_ff @(posedge clk_32m or negedge rst_n) begin
      if (!rst_n) begin
         r_smp_cnt   <= '0;
         r_prev      <= '0;
         r_match_cnt <= '0;
         r_mis_cnt   <= '0;
      end else if (!i_run) begin
         r_smp_cnt   <= '0;
         r_prev      <= '0;
         r_match_cnt <= '0;
         r_mis_cnt   <= '0;
      end else begin
         r_smp_cnt <= w_tick ? '0 : r_smp_cnt + SMP_W'(1);
         if (i_locked) begin
            r_match_cnt <= '0;
         end else begin
            r_mis_cnt <= '0;
         end
         if (w_tick) begin
            r_prev <= i_freq;
            if (i_locked) begin
               r_mis_cnt <= w_next_mis;
            end else begin
               r_match_cnt <= w_next_match;
            end
         end
      end
   end

endmodule

// File: rtl/bpsk_demod_ctrl.sv
// Sequencing controller for the BPSK demodulator (clk_32m domain).
// Flushes and enables the demodulator on start, waits for settling, then
// acquires and supervises lock on the demodulator's code-rate estimate.
// Ports:
//   clk_32m, rst_n   : 32 MHz clock, async active-low reset
//   start, abort     : single-cycle commands (abort has priority)
//   mode_req         : requested demod mode, latched at flush entry
//   freq_in          : rate estimate from the demodulator
//   demod_rst_n      : soft reset to demodulator (low during FLUSH)
//   demod_en         : demodulator output enable
//   demod_mode       : latched mode
//   freq_out         : locked rate, 0 when not locked
//   locked           : lock indication
//   timeout          : sticky acquisition-timeout flag
//   busy             : high in FLUSH, SETTLE and MEASURE
module bpsk_demod_ctrl
   import bpsk_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYC   = 16,
   parameter int unsigned SETTLE_CYC  = 32000,
   parameter int unsigned SAMPLE_CYC  = 16000,
   parameter int unsigned LOCK_CNT    = 4,
   parameter int unsigned TIMEOUT_CYC = 3200000
) (
   input  logic              clk_32m,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              mode_req,
   input  logic [FREQ_W-1:0] freq_in,
   output logic              demod_rst_n,
   output logic              demod_en,
   output logic              demod_mode,
   output logic [FREQ_W-1:0] freq_out,
   output logic              locked,
   output logic              timeout,
   output logic              busy
);

   localparam int unsigned FL_W = (FLUSH_CYC   > 1) ? $clog2(FLUSH_CYC)   : 1;
   localparam int unsigned SE_W = (SETTLE_CYC  > 1) ? $clog2(SETTLE_CYC)  : 1;
   localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   state_t            r_state;
   state_t            w_nxt_state;
   logic [FL_W-1:0]   r_flush_cnt;
   logic [SE_W-1:0]   r_settle_cnt;
   logic [TO_W-1:0]   r_to_cnt;

   logic              w_run;
   logic              w_flush_entry;
   logic              w_lock_c;
   logic              w_unlock_c;
   logic [FREQ_W-1:0] w_lock_freq_c;

   assign w_run         = (r_state == ST_MEASURE) || (r_state == ST_LOCKED);
   assign w_flush_entry = (w_nxt_state == ST_FLUSH) && (r_state != ST_FLUSH);

   bpsk_freq_lock_chk #(
      .SAMPLE_CYC (SAMPLE_CYC),
      .LOCK_CNT   (LOCK_CNT)
   ) u_lock_chk (
      .clk_32m       (clk_32m),
      .rst_n         (rst_n),
      .i_run         (w_run),
      .i_locked      (r_state == ST_LOCKED),
      .i_freq        (freq_in),
      .i_ref         (freq_out),
      .o_lock_c      (w_lock_c),
      .o_unlock_c    (w_unlock_c),
      .o_lock_freq_c (w_lock_freq_c)
   );

   // Next-state decode; abort overrides every other command
   always_comb begin
      w_nxt_state = r_state;
      if (abort) begin
         w_nxt_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    if (start) w_nxt_state = ST_FLUSH;
            ST_FLUSH:   if (r_flush_cnt == FL_W'(FLUSH_CYC - 1)) w_nxt_state = ST_SETTLE;
            ST_SETTLE:  if (r_settle_cnt == SE_W'(SETTLE_CYC - 1)) w_nxt_state = ST_MEASURE;
            ST_MEASURE: begin
               if (w_lock_c)                                 w_nxt_state = ST_LOCKED;
               else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1))  w_nxt_state = ST_FAIL;
            end
            ST_LOCKED: begin
               if (start)           w_nxt_state = ST_FLUSH;
               else if (w_unlock_c) w_nxt_state = ST_MEASURE;
            end
            ST_FAIL:    if (start) w_nxt_state = ST_FLUSH;
            default:    w_nxt_state = ST_IDLE;
         endcase
      end
   end

   // State, phase counters and registered outputs derived from the next state
   always_ff @(posedge clk_32m or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_flush_cnt  <= '0;
         r_settle_cnt <= '0;
         r_to_cnt     <= '0;
         demod_rst_n  <= 1'b1;
         demod_en     <= 1'b0;
         demod_mode   <= 1'b0;
         freq_out     <= '0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         r_state <= w_nxt_state;

         // Each counter runs only while its state is held, and restarts on entry
         if ((r_state == ST_FLUSH) && (w_nxt_state == ST_FLUSH))
            r_flush_cnt <= (r_flush_cnt == FL_W'(FLUSH_CYC - 1)) ? r_flush_cnt
                                                                 : r_flush_cnt + FL_W'(1);
         else
            r_flush_cnt <= '0;

         if ((r_state == ST_SETTLE) && (w_nxt_state == ST_SETTLE))
            r_settle_cnt <= (r_settle_cnt == SE_W'(SETTLE_CYC - 1)) ? r_settle_cnt
                                                                    : r_settle_cnt + SE_W'(1);
         else
            r_settle_cnt <= '0;

         if ((r_state == ST_MEASURE) && (w_nxt_state == ST_MEASURE))
            r_to_cnt <= (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) ? r_to_cnt
                                                             : r_to_cnt + TO_W'(1);
         else
            r_to_cnt <= '0;

         demod_rst_n <= (w_nxt_state != ST_FLUSH);
         demod_en    <= (w_nxt_state == ST_SETTLE) || (w_nxt_state == ST_MEASURE) ||
                        (w_nxt_state == ST_LOCKED);
         busy        <= (w_nxt_state == ST_FLUSH) || (w_nxt_state == ST_SETTLE) ||
                        (w_nxt_state == ST_MEASURE);
         locked      <= (w_nxt_state == ST_LOCKED);

         if (w_flush_entry)
            demod_mode <= mode_req;
         else if (w_nxt_state == ST_IDLE)
            demod_mode <= 1'b0;

         // Sticky until the next sequence starts; abort does not clear it
         if (w_flush_entry)
            timeout <= 1'b0;
         else if (w_nxt_state == ST_FAIL)
            timeout <= 1'b1;

         if ((r_state == ST_MEASURE) && (w_nxt_state == ST_LOCKED))
            freq_out <= w_lock_freq_c;
         else if (w_nxt_state != ST_LOCKED)
            freq_out <= '0;
      end
   end

endmodule

// File: tb/tb_bpsk_demod_ctrl.sv
// Directed testbench for bpsk_demod_ctrl with shortened timing parameters.
// rel counts cycles since the edge that sampled the last start pulse:
// rel = n means the outputs registered on edge t+n-1 are being observed.
module tb_bpsk_demod_ctrl;

   logic       clk_32m  = 1'b0;
   logic       rst_n    = 1'b0;
   logic       start    = 1'b0;
   logic       abort    = 1'b0;
   logic       mode_req = 1'b0;
   logic [7:0] freq_in  = 8'd0;
   logic       demod_rst_n;
   logic       demod_en;
   logic       demod_mode;
   logic [7:0] freq_out;
   logic       locked;
   logic       timeout;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int rel      = 0;

   bpsk_demod_ctrl #(
      .FLUSH_CYC   (4),
      .SETTLE_CYC  (8),
      .SAMPLE_CYC  (4),
      .LOCK_CNT    (4),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk_32m     (clk_32m),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .mode_req    (mode_req),
      .freq_in     (freq_in),
      .demod_rst_n (demod_rst_n),
      .demod_en    (demod_en),
      .demod_mode  (demod_mode),
      .freq_out    (freq_out),
      .locked      (locked),
      .timeout     (timeout),
      .busy        (busy)
   );

   always #5 clk_32m = ~clk_32m;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (rel=%0d)", tag, act, exp, rel);
      end
   endtask

   task automatic step();
      @(posedge clk_32m);
      #1;
      rel++;
   endtask

   task automatic step_to(input int n);
      while (rel < n) step();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
      rel = 1;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_rstn"},   32'(demod_rst_n), 32'd1);
      check_val({tag, "_en"},     32'(demod_en),    32'd0);
      check_val({tag, "_mode"},   32'(demod_mode),  32'd0);
      check_val({tag, "_freq"},   32'(freq_out),    32'd0);
      check_val({tag, "_locked"}, 32'(locked),      32'd0);
      check_val({tag, "_busy"},   32'(busy),        32'd0);
   endtask

   logic [7:0] seq2 [7] = '{8'd8, 8'd10, 8'd0, 8'd6, 8'd6, 8'd6, 8'd6};

   initial begin
      // Reset values
      step();
      step();
      check_idle("reset");
      check_val("reset_timeout", 32'(timeout), 32'd0);
      rst_n = 1'b1;
      step();

      // 1. Basic lock at 8 kHz, decoded mode
      mode_req = 1'b1;
      freq_in  = 8'd8;
      pulse_start();
      check_val("t1_flush_rstn", 32'(demod_rst_n), 32'd0);
      check_val("t1_flush_busy", 32'(busy),        32'd1);
      check_val("t1_flush_en",   32'(demod_en),    32'd0);
      check_val("t1_mode",       32'(demod_mode),  32'd1);
      mode_req = 1'b0;
      step_to(4);
      check_val("t1_flush_end_rstn", 32'(demod_rst_n), 32'd0);
      step_to(5);
      check_val("t1_settle_rstn", 32'(demod_rst_n), 32'd1);
      check_val("t1_settle_en",   32'(demod_en),    32'd1);
      step_to(28);
      check_val("t1_prelock", 32'(locked), 32'd0);
      step_to(29);
      check_val("t1_locked",    32'(locked),     32'd1);
      check_val("t1_freq",      32'(freq_out),   32'd8);
      check_val("t1_mode_held", 32'(demod_mode), 32'd1);
      check_val("t1_busy",      32'(busy),       32'd0);
      check_val("t1_en",        32'(demod_en),   32'd1);
      pulse_abort();
      check_idle("t1_abort");

      // 2. Unstable estimates then lock at 6 kHz on the 7th tick
      mode_req = 1'b0;
      freq_in  = 8'd0;
      pulse_start();
      for (int k = 1; k <= 7; k++) begin
         step_to(9 + 4 * k);
         freq_in = seq2[k-1];
         step_to(13 + 4 * k);
         check_val($sformatf("t2_tick%0d_locked", k), 32'(locked), (k == 7) ? 32'd1 : 32'd0);
      end
      check_val("t2_freq", 32'(freq_out),   32'd6);
      check_val("t2_mode", 32'(demod_mode), 32'd0);

      // 4. Restart from LOCKED, lock at 10, unlock with 8, relock at 8
      mode_req = 1'b1;
      freq_in  = 8'd10;
      pulse_start();
      check_val("t4_restart_locked", 32'(locked),      32'd0);
      check_val("t4_restart_freq",   32'(freq_out),    32'd0);
      check_val("t4_restart_rstn",   32'(demod_rst_n), 32'd0);
      step_to(29);
      check_val("t4_lock10",      32'(locked),   32'd1);
      check_val("t4_lock10_freq", 32'(freq_out), 32'd10);
      freq_in = 8'd8;
      step_to(44);
      check_val("t4_mis3_locked", 32'(locked), 32'd1);
      step_to(45);
      check_val("t4_unlock",      32'(locked),   32'd0);
      check_val("t4_unlock_freq", 32'(freq_out), 32'd0);
      check_val("t4_unlock_busy", 32'(busy),     32'd1);
      step_to(60);
      check_val("t4_prerelock", 32'(locked), 32'd0);
      step_to(61);
      check_val("t4_relock",      32'(locked),   32'd1);
      check_val("t4_relock_freq", 32'(freq_out), 32'd8);

      // 3. Timeout with no valid estimate
      pulse_abort();
      freq_in = 8'd0;
      pulse_start();
      step_to(112);
      check_val("t3_pre_timeout", 32'(timeout),  32'd0);
      check_val("t3_pre_busy",    32'(busy),     32'd1);
      check_val("t3_pre_en",      32'(demod_en), 32'd1);
      step_to(113);
      check_val("t3_timeout", 32'(timeout),  32'd1);
      check_val("t3_en",      32'(demod_en), 32'd0);
      check_val("t3_busy",    32'(busy),     32'd0);
      step_to(120);
      check_val("t3_fail_held", 32'(timeout), 32'd1);
      pulse_start();
      check_val("t3_restart_timeout", 32'(timeout),     32'd0);
      check_val("t3_restart_rstn",    32'(demod_rst_n), 32'd0);
      step_to(113);
      check_val("t3_timeout2", 32'(timeout), 32'd1);
      pulse_abort();
      check_val("t3_abort_timeout", 32'(timeout), 32'd1);
      check_idle("t3_abort");

      // 5. mode_req ignored in SETTLE, start ignored in SETTLE, abort beats start
      mode_req = 1'b0;
      freq_in  = 8'd8;
      pulse_start();
      step_to(6);
      mode_req = 1'b1;
      step_to(8);
      start = 1'b1;
      step();
      start = 1'b0;
      check_val("t5_settle_rstn", 32'(demod_rst_n), 32'd1);
      check_val("t5_settle_en",   32'(demod_en),    32'd1);
      check_val("t5_settle_mode", 32'(demod_mode),  32'd0);
      step_to(15);
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      check_idle("t5_prio");
      repeat (20) step();
      check_val("t5_stay_busy",   32'(busy),   32'd0);
      check_val("t5_stay_locked", 32'(locked), 32'd0);

      // 6. Asynchronous reset while LOCKED
      mode_req = 1'b1;
      freq_in  = 8'd6;
      pulse_start();
      step_to(31);
      check_val("t6_locked", 32'(locked), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("t6_async");
      check_val("t6_async_timeout", 32'(timeout), 32'd0);
      step();
      rst_n = 1'b1;
      repeat (20) step();
      check_idle("t6_no_resume");
      pulse_start();
      step_to(29);
      check_val("t6_resume_locked", 32'(locked),   32'd1);
      check_val("t6_resume_freq",   32'(freq_out), 32'd6);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
